// File: rtl/inv_pipe_gea_pkg.sv
// Shared types for the generic-cell inverter pipeline: skid-buffer occupancy states.
package inv_pipe_gea_pkg;

  typedef enum logic [1:0] {
    GEA_SKID_EMPTY = 2'd0,
    GEA_SKID_ONE   = 2'd1,
    GEA_SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_buf_gea.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid register,
// registered in_ready so there is no combinational path between the two handshakes.
module skid_buf_gea
  import inv_pipe_gea_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output skid_state_e   state
);

  // Handshake: a beat transfers on a side when valid & ready are both high at the
  // rising edge; valid never waits on ready, and once raised out_valid/out_data hold
  // until the beat is taken.
  skid_state_e   state_q, state_d;
  logic          in_ready_q;
  logic [DW-1:0] out_q, skid_q;
  logic          accept, emit;
  logic          load_out, load_skid, move_skid;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != GEA_SKID_EMPTY);
  assign out_data  = out_q;
  assign state     = state_q;

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      GEA_SKID_EMPTY: begin
        if (accept) begin
          state_d  = GEA_SKID_ONE;
          load_out = 1'b1;
        end
      end
      GEA_SKID_ONE: begin
        if (accept && emit) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = GEA_SKID_FULL;
          load_skid = 1'b1;
        end else if (emit) begin
          state_d = GEA_SKID_EMPTY;
        end
      end
      GEA_SKID_FULL: begin
        if (emit) begin
          state_d   = GEA_SKID_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = GEA_SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GEA_SKID_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      // Ready for the next cycle is decided from the state we are about to enter.
      in_ready_q <= (state_d != GEA_SKID_FULL);
      if (load_out) begin
        out_q <= in_data;
      end else if (move_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/inv_pipe_gea.sv
// Pipelined per-bit inverter bank: out = in ^ mask, mask captured at acceptance,
// streamed through a 2-entry skid buffer with 1-cycle latency.
module inv_pipe_gea
  import inv_pipe_gea_pkg::*;
#(
  parameter int                          WIDTH    = 8,
  parameter int                          CHANNELS = 4,
  parameter logic [WIDTH*CHANNELS-1:0]   RST_MASK = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mask_wr,
  input  logic [WIDTH*CHANNELS-1:0] mask_wdata,
  output logic [WIDTH*CHANNELS-1:0] mask_q,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*CHANNELS-1:0] out_data,
  output skid_state_e               skid_state
);

  localparam int DW = WIDTH * CHANNELS;

  logic [DW-1:0] mask_r;
  logic [DW-1:0] xor_data;

  assign mask_q = mask_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r <= RST_MASK;
    end else if (mask_wr) begin
      mask_r <= mask_wdata;
    end
  end

  // The XOR uses the registered mask, so a same-cycle mask_wr only affects later beats.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    assign xor_data[k*WIDTH +: WIDTH] = in_data[k*WIDTH +: WIDTH] ^ mask_r[k*WIDTH +: WIDTH];
  end

  skid_buf_gea #(
    .DW(DW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (xor_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .state     (skid_state)
  );

endmodule

// File: tb/tb_inv_pipe_gea.sv
// Bench for inv_pipe_gea: directed table + hand sequences on the default config,
// then randomized valid/ready/mask/reset traffic on three configurations against a queue model.
module tb_inv_pipe_gea;
  import inv_pipe_gea_pkg::*;

  localparam int RAND_CYCLES = 10000;

  // ---------------- clock ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic start_rand = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- directed DUT (default parameters) ----------------
  logic        rst, mask_wr, in_valid, out_ready;
  logic [31:0] mask_wdata, in_data;
  logic        in_ready, out_valid;
  logic [31:0] mask_q, out_data;
  skid_state_e skid_state;

  inv_pipe_gea dut (
    .clk        (clk),
    .rst        (rst),
    .mask_wr    (mask_wr),
    .mask_wdata (mask_wdata),
    .mask_q     (mask_q),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .skid_state (skid_state)
  );

  typedef struct {
    logic        mask_wr;
    logic [31:0] mask_wdata;
    logic [31:0] in_data;
    logic [31:0] exp_out;
    logic [31:0] exp_mask;
  } vec_t;

  vec_t tbl[21];

  // Inputs are driven right after the falling edge; outputs are checked there too.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mask_wr = 1'b0; mask_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 32'h0, 32'h0000_00A5, 32'hFFFF_FF5A, 32'hFFFF_FFFF};
    tbl[16] = '{1'b1, 32'h0000_FF00, 32'h1234_5678, 32'hEDCB_A987, 32'h0000_FF00};
    tbl[17] = '{1'b0, 32'h0,         32'h1234_5678, 32'h1234_A978, 32'h0000_FF00};
    tbl[18] = '{1'b1, 32'h0F0F_0F0F, 32'h0000_0000, 32'h0000_FF00, 32'h0F0F_0F0F};
    tbl[19] = '{1'b1, 32'h0000_00FF, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0000_00FF};
    tbl[20] = '{1'b0, 32'h0,         32'h0000_0001, 32'h0000_00FE, 32'h0000_00FF};

    // Reset: two cycles with rst high
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mask_q", 128'(mask_q), 128'(32'hFFFF_FFFF));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_data", 128'(out_data), 128'(32'h0));
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_state", 128'(skid_state), 128'(GEA_SKID_EMPTY));
    rst = 1'b0;
    cyc();
    chk("post_rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("post_rst_out_valid", 128'(out_valid), 128'(1'b0));

    // Streaming and mask-change vectors, one beat per cycle with no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      mask_wr    = tbl[i].mask_wr;
      mask_wdata = tbl[i].mask_wdata;
      in_data    = tbl[i].in_data;
      in_valid   = 1'b1;
      chk("tbl_in_ready", 128'(in_ready), 128'(1'b1));
      cyc();
      chk("tbl_out_valid", 128'(out_valid), 128'(1'b1));
      chk($sformatf("tbl_out_data[%0d]", i), 128'(out_data), 128'(tbl[i].exp_out));
      chk($sformatf("tbl_mask_q[%0d]", i), 128'(mask_q), 128'(tbl[i].exp_mask));
    end
    in_valid = 1'b0; mask_wr = 1'b0;
    cyc();
    chk("tbl_drain_out_valid", 128'(out_valid), 128'(1'b0));

    // Reset while FULL, with a simultaneous mask write that reset must override
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_00AA;
    cyc();
    in_data = 32'h0000_00BB;
    cyc();
    chk("full_state", 128'(skid_state), 128'(GEA_SKID_FULL));
    chk("full_in_ready", 128'(in_ready), 128'(1'b0));
    chk("full_out_data", 128'(out_data), 128'(32'h0000_0055));
    rst = 1'b1; mask_wr = 1'b1; mask_wdata = 32'h0; in_data = 32'h0000_00CC;
    cyc();
    chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("midrst_mask_q", 128'(mask_q), 128'(32'hFFFF_FFFF));
    chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("midrst_state", 128'(skid_state), 128'(GEA_SKID_EMPTY));
    rst = 1'b0; mask_wr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("midrst_no_replay", 128'(out_valid), 128'(1'b0));
    end

    // Backpressure: two beats accepted, third stalled, then ordered release
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    cyc();
    chk("bp_out_data_1", 128'(out_data), 128'(32'hFFFF_FFFE));
    chk("bp_in_ready_1", 128'(in_ready), 128'(1'b1));
    in_data = 32'h2;
    cyc();
    chk("bp_in_ready_2", 128'(in_ready), 128'(1'b0));
    chk("bp_hold_2", 128'(out_data), 128'(32'hFFFF_FFFE));
    in_data = 32'h3;
    cyc();
    chk("bp_in_ready_3", 128'(in_ready), 128'(1'b0));
    chk("bp_hold_3", 128'(out_data), 128'(32'hFFFF_FFFE));
    chk("bp_valid_3", 128'(out_valid), 128'(1'b1));
    out_ready = 1'b1;
    cyc();
    chk("bp_rel_2", 128'(out_data), 128'(32'hFFFF_FFFD));
    chk("bp_rel_ready", 128'(in_ready), 128'(1'b1));
    cyc();
    chk("bp_rel_3", 128'(out_data), 128'(32'hFFFF_FFFC));
    chk("bp_rel_valid", 128'(out_valid), 128'(1'b1));
    in_valid = 1'b0;
    cyc();
    chk("bp_drained", 128'(out_valid), 128'(1'b0));

    // Random phase on all configurations in parallel
    start_rand = 1'b1;
    repeat (RAND_CYCLES + 10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- randomized configurations ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int W = (g == 0) ? 8 : (g == 1) ? 1 : 16;
    localparam int C = (g == 0) ? 4 : (g == 1) ? 1 : 8;
    localparam int D = W * C;

    logic         r_rst, r_mask_wr, r_in_valid, r_out_ready;
    logic [D-1:0] r_mask_wdata, r_in_data;
    logic         r_in_ready, r_out_valid;
    logic [D-1:0] r_mask_q, r_out_data;
    skid_state_e  r_state;

    inv_pipe_gea #(.WIDTH(W), .CHANNELS(C)) u_dut (
      .clk        (clk),
      .rst        (r_rst),
      .mask_wr    (r_mask_wr),
      .mask_wdata (r_mask_wdata),
      .mask_q     (r_mask_q),
      .in_valid   (r_in_valid),
      .in_ready   (r_in_ready),
      .in_data    (r_in_data),
      .out_valid  (r_out_valid),
      .out_ready  (r_out_ready),
      .out_data   (r_out_data),
      .skid_state (r_state)
    );

    logic [D-1:0] exp_q[$];
    logic [D-1:0] m_mask;

    initial begin
      int vprob, rprob;
      logic acc, em;
      r_rst = 1'b1; r_mask_wr = 1'b0; r_mask_wdata = '0;
      r_in_valid = 1'b0; r_in_data = '0; r_out_ready = 1'b0;
      wait (start_rand);
      @(negedge clk);
      r_rst = 1'b0;
      m_mask = '1;
      exp_q.delete();
      vprob = 50; rprob = 50;
      for (int cyc_i = 0; cyc_i < RAND_CYCLES; cyc_i++) begin
        if (cyc_i % 500 == 0) begin
          vprob = $urandom_range(10, 100);
          rprob = $urandom_range(10, 100);
        end
        // Model: capacity 2; ready whenever fewer than 2 beats are held.
        chk("rand_in_ready", 128'(r_in_ready), 128'(exp_q.size() < 2));
        chk("rand_out_valid", 128'(r_out_valid), 128'(exp_q.size() > 0));
        chk("rand_mask_q", 128'(r_mask_q), 128'(m_mask));
        if (exp_q.size() > 0) chk("rand_out_data", 128'(r_out_data), 128'(exp_q[0]));

        r_rst        = ($urandom_range(0, 999) == 0);
        r_in_valid   = ($urandom_range(1, 100) <= vprob);
        r_out_ready  = ($urandom_range(1, 100) <= rprob);
        r_mask_wr    = ($urandom_range(0, 15) == 0);
        r_mask_wdata = D'(rand128());
        r_in_data    = D'(rand128());

        if (r_rst) begin
          exp_q.delete();
          m_mask = '1;
        end else begin
          acc = r_in_valid && (exp_q.size() < 2);
          em  = r_out_ready && (exp_q.size() > 0);
          if (em) void'(exp_q.pop_front());
          if (acc) exp_q.push_back(r_in_data ^ m_mask);
          if (r_mask_wr) m_mask = r_mask_wdata;
        end
        @(negedge clk);
      end
      r_in_valid = 1'b0;
      r_mask_wr  = 1'b0;
      r_rst      = 1'b0;
    end
  end

endmodule
